// File: rtl/safecrack_multikey_fsm_if.sv
// Board-facing bundle of the multi-key safe lock: debounced buttons and switches in,
// LED/status lines out. The master side drives the buttons; the slave side is the lock.
interface safecrack_multikey_fsm_if #(
  parameter int NUM_KEYS       = 4,
  parameter int CODE_LEN       = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCK_MAX_SHIFT = 3
);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int LW = $clog2(LOCK_MAX_SHIFT + 1);

  logic                prog_sw;
  logic [NUM_KEYS-1:0] keys_n;
  logic                lock_req;
  logic [2:0]          state_o;
  logic [CODE_LEN-1:0] progress;
  logic                prog_mode;
  logic                unlocked;
  logic                err_blink;
  logic                locked_out;
  logic [TW-1:0]       tries_o;
  logic [LW-1:0]       lock_level;

  modport master (
    output prog_sw, keys_n, lock_req,
    input  state_o, progress, prog_mode, unlocked, err_blink, locked_out, tries_o, lock_level
  );

  modport slave (
    input  prog_sw, keys_n, lock_req,
    output state_o, progress, prog_mode, unlocked, err_blink, locked_out, tries_o, lock_level
  );
endinterface

// File: rtl/safecrack_multikey_fsm.sv
// Multi-key safe lock: programmable N-digit code, escalating lockouts, auto relock and
// entry timeout, all paced by one shared cycle timer.
module safecrack_multikey_fsm #(
  parameter int CLOCK_HZ       = 50_000_000,
  parameter int NUM_KEYS       = 4,
  parameter int CODE_LEN       = 4,
  parameter int MAX_TRIES      = 3,
  parameter int ERR_MS         = 200,
  parameter int LOCK_S         = 10,
  parameter int LOCK_MAX_SHIFT = 3,
  parameter int RELOCK_S       = 30,
  parameter int ENTRY_TO_S     = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  safecrack_multikey_fsm_if.slave  bus
);

  localparam int DW = $clog2(NUM_KEYS);
  localparam int CW = CODE_LEN * DW;
  localparam int IW = $clog2(CODE_LEN + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int LW = $clog2(LOCK_MAX_SHIFT + 1);

  localparam longint ERR_CYC      = longint'(CLOCK_HZ) * ERR_MS / 1000;
  localparam longint LOCK_CYC     = longint'(CLOCK_HZ) * LOCK_S;
  localparam longint LOCK_MAX_CYC = LOCK_CYC << LOCK_MAX_SHIFT;
  localparam longint RELOCK_CYC   = longint'(CLOCK_HZ) * RELOCK_S;
  localparam longint ENTRY_CYC    = longint'(CLOCK_HZ) * ENTRY_TO_S;
  localparam longint MAX_A        = (LOCK_MAX_CYC > RELOCK_CYC) ? LOCK_MAX_CYC : RELOCK_CYC;
  localparam longint MAX_B        = (ENTRY_CYC > ERR_CYC) ? ENTRY_CYC : ERR_CYC;
  localparam longint MAX_CYC      = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int     TMR_W        = $clog2(MAX_CYC + 1);

  localparam logic [TMR_W-1:0] ERR_LAST    = TMR_W'(ERR_CYC - 1);
  localparam logic [TMR_W-1:0] RELOCK_LAST = TMR_W'(RELOCK_CYC - 1);
  localparam logic [TMR_W-1:0] ENTRY_LAST  = TMR_W'(ENTRY_CYC - 1);

  typedef enum logic [2:0] {
    S_PROG    = 3'd0,
    S_READY   = 3'd1,
    S_ENTRY   = 3'd2,
    S_VERIFY  = 3'd3,
    S_UNLOCK  = 3'd4,
    S_ERROR   = 3'd5,
    S_LOCKOUT = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       code_q, code_d;
  logic [CW-1:0]       attempt_q, attempt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [TW-1:0]       tries_q, tries_d;
  logic [LW-1:0]       level_q, level_d;
  logic [TMR_W-1:0]    timer_q, timer_d;

  logic [NUM_KEYS-1:0] key_s1_q, key_s2_q, key_prev_q;
  logic                prog_s1_q, prog_s2_q, prog_prev_q;
  logic                lock_prev_q;

  logic [NUM_KEYS-1:0] key_press;
  logic                key_hit;
  logic [DW-1:0]       key_digit;
  logic                prog_rise, prog_on, lock_rise;
  logic                timer_clr, timed_state;
  logic                idx_full;
  logic [TMR_W-1:0]    lock_last;

  // Two-flop synchronisers plus one history flop each for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1_q    <= '0;
      key_s2_q    <= '0;
      key_prev_q  <= '0;
      prog_s1_q   <= 1'b0;
      prog_s2_q   <= 1'b0;
      prog_prev_q <= 1'b0;
      lock_prev_q <= 1'b0;
    end else begin
      key_s1_q    <= ~bus.keys_n;
      key_s2_q    <= key_s1_q;
      key_prev_q  <= key_s2_q;
      prog_s1_q   <= bus.prog_sw;
      prog_s2_q   <= prog_s1_q;
      prog_prev_q <= prog_s2_q;
      lock_prev_q <= bus.lock_req;
    end
  end

  assign key_press = key_s2_q & ~key_prev_q;
  assign prog_on   = prog_s2_q;
  assign prog_rise = prog_s2_q & ~prog_prev_q;
  assign lock_rise = bus.lock_req & ~lock_prev_q;

  // Scan from the top so the lowest-numbered simultaneous press is the one kept.
  always_comb begin
    key_hit   = 1'b0;
    key_digit = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (key_press[k]) begin
        key_hit   = 1'b1;
        key_digit = DW'(k);
      end
    end
  end

  assign idx_full    = (idx_q == IW'(CODE_LEN));
  assign lock_last   = (TMR_W'(LOCK_CYC) << level_q) - TMR_W'(1);
  assign timed_state = (state_q == S_ENTRY) || (state_q == S_ERROR) ||
                       (state_q == S_LOCKOUT) || (state_q == S_UNLOCK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_PROG;
      code_q    <= '0;
      attempt_q <= '0;
      idx_q     <= '0;
      tries_q   <= '0;
      level_q   <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      attempt_q <= attempt_d;
      idx_q     <= idx_d;
      tries_q   <= tries_d;
      level_q   <= level_d;
      timer_q   <= timer_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    attempt_d = attempt_q;
    idx_d     = idx_q;
    tries_d   = tries_q;
    level_d   = level_q;
    timer_clr = 1'b0;

    unique case (state_q)
      S_PROG: begin
        if (key_hit && !idx_full) begin
          code_d = (code_q << DW) | CW'(key_digit);
          idx_d  = idx_q + IW'(1);
        end
        if (!prog_on && idx_full) begin
          state_d = S_READY;
        end
      end

      S_READY: begin
        if (key_hit) begin
          state_d   = S_ENTRY;
          idx_d     = '0;
          attempt_d = '0;
        end
      end

      S_ENTRY: begin
        if (idx_full) begin
          state_d = S_VERIFY;
        end else if (key_hit) begin
          attempt_d = (attempt_q << DW) | CW'(key_digit);
          idx_d     = idx_q + IW'(1);
          timer_clr = 1'b1;
        end else if (ENTRY_TO_S != 0 && timer_q == ENTRY_LAST) begin
          state_d = S_READY;
        end
      end

      S_VERIFY: begin
        if (attempt_q == code_q) begin
          state_d = S_UNLOCK;
          tries_d = '0;
          level_d = '0;
        end else begin
          tries_d = (tries_q == TW'(MAX_TRIES)) ? tries_q : tries_q + TW'(1);
          if (({1'b0, tries_q} + (TW+1)'(1)) == (TW+1)'(MAX_TRIES)) begin
            state_d = S_LOCKOUT;
          end else begin
            state_d = S_ERROR;
          end
        end
      end

      S_ERROR: begin
        if (timer_q == ERR_LAST) begin
          state_d = S_READY;
        end
      end

      S_LOCKOUT: begin
        if (timer_q == lock_last) begin
          state_d = S_READY;
          tries_d = '0;
          level_d = (level_q == LW'(LOCK_MAX_SHIFT)) ? level_q : level_q + LW'(1);
        end
      end

      S_UNLOCK: begin
        if (lock_rise || (RELOCK_S != 0 && timer_q == RELOCK_LAST)) begin
          state_d = S_READY;
        end
      end

      default: state_d = S_PROG;
    endcase

    if (prog_on) begin
      state_d = S_PROG;
    end

    // A fresh programming request wipes everything, including lockout escalation.
    if (prog_rise) begin
      state_d   = S_PROG;
      code_d    = '0;
      attempt_d = '0;
      idx_d     = '0;
      tries_d   = '0;
      level_d   = '0;
      timer_clr = 1'b1;
    end
  end

  always_comb begin
    timer_d = timer_q;
    if (timer_clr || (state_d != state_q)) begin
      timer_d = '0;
    end else if (timed_state) begin
      timer_d = timer_q + TMR_W'(1);
    end
  end

  assign bus.state_o    = state_q;
  assign bus.prog_mode  = (state_q == S_PROG);
  assign bus.unlocked   = (state_q == S_UNLOCK);
  assign bus.err_blink  = (state_q == S_ERROR);
  assign bus.locked_out = (state_q == S_LOCKOUT);
  assign bus.tries_o    = tries_q;
  assign bus.lock_level = level_q;

  logic capture_phase;
  assign capture_phase = (state_q == S_PROG) || (state_q == S_ENTRY);

  for (genvar gi = 0; gi < CODE_LEN; gi++) begin : g_progress
    assign bus.progress[gi] = capture_phase && (idx_q > IW'(gi));
  end

endmodule

// File: tb/tb_safecrack_multikey_fsm.sv
// Randomised bench for the multi-key safe lock, scored against a transaction-level
// model of code, tries and lockout escalation plus measured timed-state lengths.
module tb_safecrack_multikey_fsm;

  localparam int CLOCK_HZ       = 100;
  localparam int NUM_KEYS       = 4;
  localparam int CODE_LEN       = 4;
  localparam int MAX_TRIES      = 3;
  localparam int ERR_MS         = 200;
  localparam int LOCK_S         = 10;
  localparam int LOCK_MAX_SHIFT = 3;
  localparam int RELOCK_S       = 5;
  localparam int ENTRY_TO_S     = 2;

  localparam int ERR_CYC    = CLOCK_HZ * ERR_MS / 1000;
  localparam int LOCK_CYC   = CLOCK_HZ * LOCK_S;
  localparam int RELOCK_CYC = CLOCK_HZ * RELOCK_S;
  localparam int ENTRY_CYC  = CLOCK_HZ * ENTRY_TO_S;

  localparam int ST_PROG    = 0;
  localparam int ST_READY   = 1;
  localparam int ST_ENTRY   = 2;
  localparam int ST_VERIFY  = 3;
  localparam int ST_UNLOCK  = 4;
  localparam int ST_ERROR   = 5;
  localparam int ST_LOCKOUT = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  safecrack_multikey_fsm_if #(
    .NUM_KEYS(NUM_KEYS), .CODE_LEN(CODE_LEN),
    .MAX_TRIES(MAX_TRIES), .LOCK_MAX_SHIFT(LOCK_MAX_SHIFT)
  ) bus ();

  safecrack_multikey_fsm #(
    .CLOCK_HZ(CLOCK_HZ), .NUM_KEYS(NUM_KEYS), .CODE_LEN(CODE_LEN),
    .MAX_TRIES(MAX_TRIES), .ERR_MS(ERR_MS), .LOCK_S(LOCK_S),
    .LOCK_MAX_SHIFT(LOCK_MAX_SHIFT), .RELOCK_S(RELOCK_S), .ENTRY_TO_S(ENTRY_TO_S)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks  = 0;
  int errors  = 0;
  int txn     = 0;
  int code_m[CODE_LEN];
  int tries_m = 0;
  int level_m = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int thermo(input int n);
    return (1 << n) - 1;
  endfunction

  function automatic string digits_str(input int d[CODE_LEN]);
    string s;
    s = "";
    for (int i = 0; i < CODE_LEN; i++) s = {s, $sformatf("%0d", d[i])};
    return s;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Holds the key(s) low for three cycles, long enough for the capture edge to pass.
  task automatic press(input int k, input int also);
    bus.keys_n[k] = 1'b0;
    if (also >= 0) bus.keys_n[also] = 1'b0;
    tick(3);
    bus.keys_n = '1;
  endtask

  task automatic measure(input int st, input int budget, output int len);
    len = 0;
    while (int'(bus.state_o) == st && len < budget) begin
      len++;
      tick(1);
    end
  endtask

  task automatic make_wrong(output int d[CODE_LEN]);
    bit same;
    do begin
      same = 1'b1;
      for (int i = 0; i < CODE_LEN; i++) begin
        d[i] = int'($urandom_range(0, NUM_KEYS - 1));
        if (d[i] != code_m[i]) same = 1'b0;
      end
    end while (same);
  endtask

  task automatic program_code(input int d[CODE_LEN], input bit drop_early);
    bus.prog_sw = 1'b1;
    tick(4);
    check_eq("prog_state", 64'(bus.state_o), 64'(ST_PROG));
    check_eq("prog_mode", 64'(bus.prog_mode), 64'(1));
    check_eq("prog_tries", 64'(bus.tries_o), 64'(0));
    check_eq("prog_level", 64'(bus.lock_level), 64'(0));
    for (int i = 0; i < CODE_LEN; i++) begin
      press(d[i], -1);
      check_eq("prog_progress", 64'(bus.progress), 64'(thermo(i + 1)));
      tick(3);
      if (drop_early && i == 1) begin
        bus.prog_sw = 1'b0;
        tick(4);
        check_eq("prog_hold", 64'(bus.state_o), 64'(ST_PROG));
      end
    end
    bus.prog_sw = 1'b0;
    tick(4);
    check_eq("prog_done", 64'(bus.state_o), 64'(ST_READY));
    for (int i = 0; i < CODE_LEN; i++) code_m[i] = d[i];
    tries_m = 0;
    level_m = 0;
    txn++;
    $display("txn %0d: program code %s (early drop %0d)", txn, digits_str(d), drop_early);
  endtask

  task automatic attempt(input int d[CODE_LEN], input bit relock_wait,
                         input bit stop_lockout, output int verdict);
    int also, len, dly;
    bit ok;
    press(int'($urandom_range(0, NUM_KEYS - 1)), -1);
    check_eq("wake_state", 64'(bus.state_o), 64'(ST_ENTRY));
    check_eq("wake_progress", 64'(bus.progress), 64'(0));
    tick(3);
    for (int i = 0; i < CODE_LEN; i++) begin
      also = -1;
      if (d[i] < NUM_KEYS - 1 && $urandom_range(0, 3) == 0)
        also = int'($urandom_range(d[i] + 1, NUM_KEYS - 1));
      press(d[i], also);
      check_eq("entry_progress", 64'(bus.progress), 64'(thermo(i + 1)));
      if (i < CODE_LEN - 1) tick(3);
    end
    tick(1);
    check_eq("verify_state", 64'(bus.state_o), 64'(ST_VERIFY));
    check_eq("verify_progress", 64'(bus.progress), 64'(0));
    tick(1);
    ok = 1'b1;
    for (int i = 0; i < CODE_LEN; i++) if (d[i] != code_m[i]) ok = 1'b0;
    if (ok) begin
      tries_m = 0;
      level_m = 0;
      verdict = ST_UNLOCK;
    end else begin
      if (tries_m < MAX_TRIES) tries_m++;
      verdict = (tries_m == MAX_TRIES) ? ST_LOCKOUT : ST_ERROR;
    end
    txn++;
    $display("txn %0d: attempt %s -> expect state %0d tries %0d level %0d",
             txn, digits_str(d), verdict, tries_m, level_m);
    check_eq("verdict_state", 64'(bus.state_o), 64'(verdict));
    check_eq("verdict_tries", 64'(bus.tries_o), 64'(tries_m));
    case (verdict)
      ST_UNLOCK: begin
        check_eq("unlocked", 64'(bus.unlocked), 64'(1));
        check_eq("unlock_level", 64'(bus.lock_level), 64'(0));
        if (relock_wait) begin
          measure(ST_UNLOCK, RELOCK_CYC + 10, len);
          check_eq("relock_len", 64'(len), 64'(RELOCK_CYC));
        end else begin
          dly = int'($urandom_range(1, 100));
          tick(dly);
          bus.lock_req = 1'b1;
          tick(1);
          bus.lock_req = 1'b0;
        end
        check_eq("relock_state", 64'(bus.state_o), 64'(ST_READY));
      end
      ST_ERROR: begin
        check_eq("err_blink", 64'(bus.err_blink), 64'(1));
        measure(ST_ERROR, ERR_CYC + 10, len);
        check_eq("error_len", 64'(len), 64'(ERR_CYC));
        check_eq("error_exit", 64'(bus.state_o), 64'(ST_READY));
      end
      default: begin
        check_eq("locked_out", 64'(bus.locked_out), 64'(1));
        if (!stop_lockout) begin
          measure(ST_LOCKOUT, (LOCK_CYC << level_m) + 10, len);
          check_eq("lockout_len", 64'(len), 64'(LOCK_CYC << level_m));
          tries_m = 0;
          if (level_m < LOCK_MAX_SHIFT) level_m++;
          check_eq("lockout_exit", 64'(bus.state_o), 64'(ST_READY));
          check_eq("lockout_tries", 64'(bus.tries_o), 64'(tries_m));
          check_eq("lockout_level", 64'(bus.lock_level), 64'(level_m));
        end
      end
    endcase
  endtask

  task automatic idle_timeout(input int ndig);
    int len;
    press(int'($urandom_range(0, NUM_KEYS - 1)), -1);
    check_eq("to_wake", 64'(bus.state_o), 64'(ST_ENTRY));
    for (int i = 0; i < ndig; i++) begin
      tick(3);
      press(int'($urandom_range(0, NUM_KEYS - 1)), -1);
    end
    measure(ST_ENTRY, ENTRY_CYC + 10, len);
    txn++;
    $display("txn %0d: idle after %0d digits, entry held %0d cycles", txn, ndig, len);
    check_eq("timeout_len", 64'(len), 64'(ENTRY_CYC));
    check_eq("timeout_state", 64'(bus.state_o), 64'(ST_READY));
    check_eq("timeout_tries", 64'(bus.tries_o), 64'(tries_m));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d[CODE_LEN];
    int v, r;
    bus.prog_sw  = 1'b0;
    bus.keys_n   = '1;
    bus.lock_req = 1'b0;
    rst_n        = 1'b0;
    tick(3);
    check_eq("rst_state", 64'(bus.state_o), 64'(ST_PROG));
    check_eq("rst_prog_mode", 64'(bus.prog_mode), 64'(1));
    check_eq("rst_progress", 64'(bus.progress), 64'(0));
    check_eq("rst_unlocked", 64'(bus.unlocked), 64'(0));
    check_eq("rst_err", 64'(bus.err_blink), 64'(0));
    check_eq("rst_locked", 64'(bus.locked_out), 64'(0));
    check_eq("rst_tries", 64'(bus.tries_o), 64'(0));
    check_eq("rst_level", 64'(bus.lock_level), 64'(0));
    rst_n = 1'b1;
    tick(2);

    bus.lock_req = 1'b1;
    tick(1);
    bus.lock_req = 1'b0;
    tick(1);
    check_eq("lockreq_ignored_prog", 64'(bus.state_o), 64'(ST_PROG));

    d = '{1, 2, 3, 0};
    program_code(d, 1'b0);
    attempt(code_m, 1'b0, 1'b0, v);
    attempt(code_m, 1'b1, 1'b0, v);

    for (int n = 0; n < 2 * MAX_TRIES; n++) begin
      make_wrong(d);
      attempt(d, 1'b0, 1'b0, v);
    end
    make_wrong(d);
    attempt(d, 1'b0, 1'b0, v);

    bus.lock_req = 1'b1;
    tick(1);
    bus.lock_req = 1'b0;
    tick(2);
    check_eq("lockreq_ignored_ready", 64'(bus.state_o), 64'(ST_READY));

    idle_timeout(2);
    attempt(code_m, 1'b0, 1'b0, v);

    for (int n = 0; n < 10; n++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 3) begin
        attempt(code_m, 1'($urandom_range(0, 1)), 1'b0, v);
      end else if (r <= 5) begin
        make_wrong(d);
        attempt(d, 1'b0, 1'b0, v);
      end else if (r <= 7) begin
        idle_timeout(int'($urandom_range(0, CODE_LEN - 1)));
      end else begin
        for (int i = 0; i < CODE_LEN; i++) d[i] = int'($urandom_range(0, NUM_KEYS - 1));
        program_code(d, 1'($urandom_range(0, 1)));
      end
    end

    // Reprogram in the middle of an entry; the old code must stop working.
    make_wrong(d);
    attempt(d, 1'b0, 1'b0, v);
    press(int'($urandom_range(0, NUM_KEYS - 1)), -1);
    tick(3);
    for (int i = 0; i < 2; i++) begin
      press(int'($urandom_range(0, NUM_KEYS - 1)), -1);
      tick(3);
    end
    bus.prog_sw = 1'b1;
    tick(2);
    check_eq("reprog_latency", 64'(bus.state_o), 64'(ST_ENTRY));
    tick(1);
    check_eq("reprog_state", 64'(bus.state_o), 64'(ST_PROG));
    check_eq("reprog_progress", 64'(bus.progress), 64'(0));
    check_eq("reprog_tries", 64'(bus.tries_o), 64'(0));
    begin
      int old_code[CODE_LEN];
      for (int i = 0; i < CODE_LEN; i++) old_code[i] = code_m[i];
      make_wrong(d);
      program_code(d, 1'b0);
      attempt(old_code, 1'b0, 1'b0, v);
      check_eq("old_code_rejected", 64'(v == ST_UNLOCK), 64'(0));
    end

    // Drive into lockout, then pull reset in the middle of it.
    v = ST_ERROR;
    for (int n = 0; n <= MAX_TRIES && v != ST_LOCKOUT; n++) begin
      make_wrong(d);
      attempt(d, 1'b0, 1'b1, v);
    end
    check_eq("lockout_reached", 64'(bus.state_o), 64'(ST_LOCKOUT));
    tick(100);
    rst_n = 1'b0;
    #1;
    txn++;
    $display("txn %0d: reset asserted mid-lockout", txn);
    check_eq("arst_state", 64'(bus.state_o), 64'(ST_PROG));
    check_eq("arst_prog_mode", 64'(bus.prog_mode), 64'(1));
    check_eq("arst_locked", 64'(bus.locked_out), 64'(0));
    check_eq("arst_tries", 64'(bus.tries_o), 64'(0));
    check_eq("arst_level", 64'(bus.lock_level), 64'(0));
    check_eq("arst_progress", 64'(bus.progress), 64'(0));
    check_eq("arst_unlocked", 64'(bus.unlocked), 64'(0));
    check_eq("arst_err", 64'(bus.err_blink), 64'(0));
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
